// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order reorder buffer fed by the rename stage.
//
// Allocates one entry per renamed instruction at the tail. Each entry holds the
// architectural rd, the new physical tag and the previous mapping. Entries are
// marked done when they complete, and at most one entry retires per cycle from
// the head, in program order. On retirement the superseded physical register
// goes back to the free pool.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   alloc_valid / alloc_ready      allocation handshake (ready = !full, no bypass)
//   alloc_reg_write, alloc_areg,   fields of the instruction being allocated
//   alloc_preg, alloc_old_preg,
//   alloc_pc
//   alloc_idx                      ROB index this allocation will occupy (tail)
//   cmpl_valid, cmpl_idx           completion of the instruction at cmpl_idx
//   retire_valid                   one-cycle pulse per retired entry
//   retire_areg/preg/pc            fields of the retired entry (held otherwise)
//   push_free_reg, freed_reg       physical register returned to the free pool
//   count, empty, full             occupancy status
module reorder_buffer #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned IDX_WIDTH  = 4,
    parameter int unsigned PREG_WIDTH = 6,
    parameter int unsigned AREG_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic                  alloc_reg_write,
    input  logic [AREG_WIDTH-1:0] alloc_areg,
    input  logic [PREG_WIDTH-1:0] alloc_preg,
    input  logic [PREG_WIDTH-1:0] alloc_old_preg,
    input  logic [31:0]           alloc_pc,
    output logic [IDX_WIDTH-1:0]  alloc_idx,
    input  logic                  cmpl_valid,
    input  logic [IDX_WIDTH-1:0]  cmpl_idx,
    output logic                  retire_valid,
    output logic [AREG_WIDTH-1:0] retire_areg,
    output logic [PREG_WIDTH-1:0] retire_preg,
    output logic [31:0]           retire_pc,
    output logic                  push_free_reg,
    output logic [PREG_WIDTH-1:0] freed_reg,
    output logic [IDX_WIDTH:0]    count,
    output logic                  empty,
    output logic                  full
);

    localparam logic [IDX_WIDTH:0] FULL_COUNT = (IDX_WIDTH + 1)'(DEPTH);

    // Entry storage
    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0]      ent_done;
    logic [DEPTH-1:0]      ent_reg_write;
    logic [AREG_WIDTH-1:0] ent_areg     [DEPTH];
    logic [PREG_WIDTH-1:0] ent_preg     [DEPTH];
    logic [PREG_WIDTH-1:0] ent_old_preg [DEPTH];
    logic [31:0]           ent_pc       [DEPTH];

    logic [IDX_WIDTH-1:0] head;
    logic [IDX_WIDTH-1:0] tail;
    logic [IDX_WIDTH:0]   count_d;

    logic                  alloc_fire;
    logic                  retire_fire;
    logic [PREG_WIDTH-1:0] freed_reg_d;

    always_comb begin
        full        = (count == FULL_COUNT);
        empty       = (count == '0);
        alloc_ready = !full;
        alloc_idx   = tail;
        alloc_fire  = alloc_valid && alloc_ready;
        // done is read from state only, so a completion landing this edge is
        // seen by the retire check one edge later.
        retire_fire = ent_valid[head] && ent_done[head];
    end

    // Occupancy: simultaneous allocate and retire leaves count unchanged.
    always_comb begin
        count_d = count;
        unique case ({alloc_fire, retire_fire})
            2'b10:   count_d = count + (IDX_WIDTH + 1)'(1);
            2'b01:   count_d = count - (IDX_WIDTH + 1)'(1);
            default: count_d = count;
        endcase
    end

    // x0 writes never consume their popped tag, so the new tag is returned
    // instead of the old mapping.
    always_comb begin
        freed_reg_d = '0;
        if (ent_reg_write[head]) begin
            freed_reg_d = (ent_areg[head] != '0) ? ent_old_preg[head] : ent_preg[head];
        end
    end

    // Valid/done flags. Allocation never targets the retiring slot: when the
    // buffer is empty the head slot is invalid, and when full allocation is off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            ent_done  <= '0;
        end else begin
            if (cmpl_valid && ent_valid[cmpl_idx]) begin
                ent_done[cmpl_idx] <= 1'b1;
            end
            if (retire_fire) begin
                ent_valid[head] <= 1'b0;
                ent_done[head]  <= 1'b0;
            end
            if (alloc_fire) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
            end
        end
    end

    // Payload fields are only meaningful while valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_reg_write[tail] <= alloc_reg_write;
            ent_areg[tail]      <= alloc_areg;
            ent_preg[tail]      <= alloc_preg;
            ent_old_preg[tail]  <= alloc_old_preg;
            ent_pc[tail]        <= alloc_pc;
        end
    end

    // Pointers wrap naturally since DEPTH == 2**IDX_WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + IDX_WIDTH'(1);
            end
            if (retire_fire) begin
                head <= head + IDX_WIDTH'(1);
            end
            count <= count_d;
        end
    end

    // Registered retire / free-list outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_valid  <= 1'b0;
            retire_areg   <= '0;
            retire_preg   <= '0;
            retire_pc     <= '0;
            push_free_reg <= 1'b0;
            freed_reg     <= '0;
        end else begin
            retire_valid  <= retire_fire;
            push_free_reg <= retire_fire && ent_reg_write[head];
            if (retire_fire) begin
                retire_areg <= ent_areg[head];
                retire_preg <= ent_preg[head];
                retire_pc   <= ent_pc[head];
                freed_reg   <= freed_reg_d;
            end
        end
    end

endmodule
